// File: rtl/play_area_pkg.sv
// Shared cell codes, sweep state type and border helper for play_area_grid.
// Optional build macro: PLAY_AREA_BORDER_EN (sweep paints a wall border).
package play_area_pkg;

    localparam int CELL_EMPTY = 0;
    localparam int CELL_WALL  = 1;
    localparam int CELL_SNAKE = 2;
    localparam int CELL_FOOD  = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic is_border(
        input int x,
        input int y,
        input int w,
        input int h
    );
        return (x == 0) || (x == w - 1) || (y == 0) || (y == h - 1);
    endfunction

endpackage

// File: rtl/play_area_clear_seq.sv
// Field clear sequencer: sweeps every active cell once after reset or request.
// With PLAY_AREA_BORDER_EN the edge cells are painted as wall.
module play_area_clear_seq
    import play_area_pkg::*;
#(
    parameter int X_BITS    = 7,
    parameter int Y_BITS    = 6,
    parameter int WIDTH     = 80,
    parameter int HEIGHT    = 60,
    parameter int CELL_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 sw_we,
    output logic [X_BITS-1:0]    sw_x,
    output logic [Y_BITS-1:0]    sw_y,
    output logic [CELL_BITS-1:0] sw_data
);

    state_t            state;
    logic [X_BITS-1:0] cx;
    logic [Y_BITS-1:0] cy;
    logic              last_col;
    logic              last_row;

    assign last_col = (cx == X_BITS'(WIDTH - 1));
    assign last_row = (cy == Y_BITS'(HEIGHT - 1));

    // Sweep FSM: raster-walks (cx,cy) and drops back to idle after the last cell
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            cx    <= '0;
            cy    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (last_col) begin
                        cx <= '0;
                        if (last_row) begin
                            state <= ST_IDLE;
                            cy    <= '0;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_CLEAR);
    assign sw_we = busy;
    assign sw_x  = cx;
    assign sw_y  = cy;

    // Value painted into the current sweep cell
    always_comb begin
`ifdef PLAY_AREA_BORDER_EN
        if (is_border(int'(cx), int'(cy), WIDTH, HEIGHT))
            sw_data = CELL_BITS'(CELL_WALL);
        else
            sw_data = CELL_BITS'(CELL_EMPTY);
`else
        sw_data = CELL_BITS'(CELL_EMPTY);
`endif
    end

endmodule

// File: rtl/play_area_grid.sv
// Play-field RAM: handshaked game port with old-value return, video scan port.
// Optional build macro: PLAY_AREA_BORDER_EN (see play_area_clear_seq).
module play_area_grid
    import play_area_pkg::*;
#(
    parameter int X_BITS    = 7,
    parameter int Y_BITS    = 6,
    parameter int WIDTH     = 80,
    parameter int HEIGHT    = 60,
    parameter int CELL_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_req,
    output logic                 busy,
    input  logic                 g_valid,
    output logic                 g_ready,
    input  logic [X_BITS-1:0]    g_x,
    input  logic [Y_BITS-1:0]    g_y,
    input  logic                 g_we,
    input  logic [CELL_BITS-1:0] g_wdata,
    output logic                 g_rvalid,
    output logic [CELL_BITS-1:0] g_rdata,
    input  logic [X_BITS-1:0]    v_x,
    input  logic [Y_BITS-1:0]    v_y,
    output logic [CELL_BITS-1:0] v_rdata
);

    localparam int AW    = X_BITS + Y_BITS;
    localparam int DEPTH = 2 ** AW;
    localparam logic [CELL_BITS-1:0] WALL = CELL_BITS'(CELL_WALL);

    logic [CELL_BITS-1:0] mem [DEPTH];

    logic                 sw_we;
    logic [X_BITS-1:0]    sw_x;
    logic [Y_BITS-1:0]    sw_y;
    logic [CELL_BITS-1:0] sw_data;

    logic                 accept;
    logic                 g_in;
    logic                 v_in;
    logic [AW-1:0]        g_addr;
    logic [AW-1:0]        v_addr;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [CELL_BITS-1:0] mem_wd;

    play_area_clear_seq #(
        .X_BITS   (X_BITS),
        .Y_BITS   (Y_BITS),
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .CELL_BITS(CELL_BITS)
    ) u_clear (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_req(clear_req),
        .busy     (busy),
        .sw_we    (sw_we),
        .sw_x     (sw_x),
        .sw_y     (sw_y),
        .sw_data  (sw_data)
    );

    assign g_ready = !busy && !clear_req;
    assign accept  = g_valid && g_ready;
    assign g_in    = (int'(g_x) < WIDTH) && (int'(g_y) < HEIGHT);
    assign v_in    = (int'(v_x) < WIDTH) && (int'(v_y) < HEIGHT);
    assign g_addr  = {g_y, g_x};
    assign v_addr  = {v_y, v_x};

    // Write mux: the sweep owns the RAM while busy, otherwise the game port
    always_comb begin
        if (sw_we) begin
            mem_we   = 1'b1;
            mem_addr = {sw_y, sw_x};
            mem_wd   = sw_data;
        end else begin
            mem_we   = accept && g_we && g_in;
            mem_addr = g_addr;
            mem_wd   = g_wdata;
        end
    end

    // Storage array, deliberately left unreset
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wd;
    end

    // Registered read paths; both sample the pre-write contents
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_rvalid <= 1'b0;
            g_rdata  <= '0;
            v_rdata  <= '0;
        end else begin
            g_rvalid <= accept;
            if (accept)
                g_rdata <= g_in ? mem[g_addr] : WALL;
            v_rdata <= (busy || !v_in) ? '0 : mem[v_addr];
        end
    end

endmodule
